// File: rtl/adc_seq_pkg.sv
// Shared types and defaults for the SAR ADC burst sequencer.
package adc_seq_pkg;

   localparam int RES_W_DEF   = 5;
   localparam int LEN_W_DEF   = 8;
   localparam int GAP_W_DEF   = 8;
   localparam int TMO_CYC_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_GO   = 3'd1,
      ST_WAIT = 3'd2,
      ST_GAP  = 3'd3,
      ST_FIN  = 3'd4
   } seq_state_e;

   // Accumulator width: one LEN_W-bit count of RES_W-bit samples cannot overflow it.
   function automatic int sum_width(input int res_w, input int len_w);
      return res_w + len_w;
   endfunction

endpackage

// File: rtl/adc_stat_accum.sv
// Working sum/min/max accumulator plus the published statistics of the last
// completed burst. A publish coinciding with a capture folds that sample in,
// so the final result is visible the cycle after its VALID edge.
module adc_stat_accum
   import adc_seq_pkg::*;
#(
   parameter int  RES_W = RES_W_DEF,
   parameter int  LEN_W = LEN_W_DEF,
   localparam int SUM_W = sum_width(RES_W, LEN_W)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             capture_i,
   input  logic             publish_i,
   input  logic [RES_W-1:0] result_i,
   output logic [SUM_W-1:0] sum_o,
   output logic [RES_W-1:0] min_o,
   output logic [RES_W-1:0] max_o
);

   logic [SUM_W-1:0] work_sum_q, work_sum_d;
   logic [RES_W-1:0] work_min_q, work_min_d;
   logic [RES_W-1:0] work_max_q, work_max_d;
   logic [SUM_W-1:0] stat_sum_q, stat_sum_d;
   logic [RES_W-1:0] stat_min_q, stat_min_d;
   logic [RES_W-1:0] stat_max_q, stat_max_d;
   logic [SUM_W-1:0] fold_sum_s;
   logic [RES_W-1:0] fold_min_s;
   logic [RES_W-1:0] fold_max_s;

   // Working values with the incoming sample folded in.
   always_comb begin
      fold_sum_s = work_sum_q + SUM_W'(result_i);
      if (result_i < work_min_q) begin
         fold_min_s = result_i;
      end else begin
         fold_min_s = work_min_q;
      end
      if (result_i > work_max_q) begin
         fold_max_s = result_i;
      end else begin
         fold_max_s = work_max_q;
      end
   end

   // Next-state selection for working and published registers.
   always_comb begin
      work_sum_d = work_sum_q;
      work_min_d = work_min_q;
      work_max_d = work_max_q;
      stat_sum_d = stat_sum_q;
      stat_min_d = stat_min_q;
      stat_max_d = stat_max_q;
      if (clear_i) begin
         work_sum_d = {SUM_W{1'b0}};
         work_min_d = {RES_W{1'b1}};
         work_max_d = {RES_W{1'b0}};
      end else if (capture_i) begin
         work_sum_d = fold_sum_s;
         work_min_d = fold_min_s;
         work_max_d = fold_max_s;
      end else begin
         work_sum_d = work_sum_q;
      end
      if (capture_i && publish_i) begin
         stat_sum_d = fold_sum_s;
         stat_min_d = fold_min_s;
         stat_max_d = fold_max_s;
      end else begin
         stat_sum_d = stat_sum_q;
      end
   end

   // Accumulator and statistics registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         work_sum_q <= {SUM_W{1'b0}};
         work_min_q <= {RES_W{1'b0}};
         work_max_q <= {RES_W{1'b0}};
         stat_sum_q <= {SUM_W{1'b0}};
         stat_min_q <= {RES_W{1'b0}};
         stat_max_q <= {RES_W{1'b0}};
      end else begin
         work_sum_q <= work_sum_d;
         work_min_q <= work_min_d;
         work_max_q <= work_max_d;
         stat_sum_q <= stat_sum_d;
         stat_min_q <= stat_min_d;
         stat_max_q <= stat_max_d;
      end
   end

   assign sum_o = stat_sum_q;
   assign min_o = stat_min_q;
   assign max_o = stat_max_q;

endmodule

// File: rtl/adc_burst_sequencer.sv
// Drives the SAR ADC GO/VALID handshake for bursts of conversions and
// publishes sum/min/max of each completed burst. Runs on the ADC clock.
module adc_burst_sequencer
   import adc_seq_pkg::*;
#(
   parameter int  RES_W   = RES_W_DEF,
   parameter int  LEN_W   = LEN_W_DEF,
   parameter int  GAP_W   = GAP_W_DEF,
   parameter int  TMO_CYC = TMO_CYC_DEF,
   localparam int SUM_W   = sum_width(RES_W, LEN_W)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [LEN_W-1:0] cfg_len_i,
   input  logic [GAP_W-1:0] cfg_gap_i,
   input  logic             cfg_cont_i,
   input  logic             adc_valid_i,
   input  logic             adc_sample_i,
   input  logic [RES_W-1:0] adc_result_i,
   output logic             adc_go_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             err_tmo_o,
   output logic [SUM_W-1:0] stat_sum_o,
   output logic [RES_W-1:0] stat_min_o,
   output logic [RES_W-1:0] stat_max_o,
   output logic [LEN_W-1:0] stat_cnt_o
);

   localparam int            TW       = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

   seq_state_e       state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic             cont_q, cont_d;
   logic             err_q, err_d;
   logic             valid_q;

   logic             start_ok_s;
   logic             edge_s;
   logic             last_s;
   logic             tmo_exp_s;
   logic             gap_end_s;
   logic             rearm_s;
   logic             clear_s;
   logic             capture_s;
   logic             publish_s;

   // Decoded conditions shared by the FSM and the datapath.
   always_comb begin
      start_ok_s = start_i && (cfg_len_i != {LEN_W{1'b0}}) && !abort_i && (state_q == ST_IDLE);
      edge_s     = adc_valid_i && !valid_q && !abort_i;
      last_s     = ((cnt_q + LEN_W'(1)) == len_q);
      tmo_exp_s  = (tmo_q == TMO_LAST);
      gap_end_s  = (gap_cnt_q == (gap_q - GAP_W'(1)));
      rearm_s    = cont_q && cfg_cont_i;
   end

   // FSM state register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; ABORT overrides every transition.
   always_comb begin
      state_d = state_q;
      if (abort_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok_s) begin
                  state_d = ST_GO;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_GO:   state_d = ST_WAIT;
            ST_WAIT: begin
               if (edge_s) begin
                  if (last_s) begin
                     state_d = ST_FIN;
                  end else if (gap_q == {GAP_W{1'b0}}) begin
                     state_d = ST_GO;
                  end else begin
                     state_d = ST_GAP;
                  end
               end else if (tmo_exp_s) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
            ST_GAP: begin
               if (gap_end_s) begin
                  state_d = ST_GO;
               end else begin
                  state_d = ST_GAP;
               end
            end
            ST_FIN: begin
               if (rearm_s) begin
                  state_d = ST_GO;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // FSM outputs, decoded from the state register.
   always_comb begin
      adc_go_o  = (state_q == ST_GO);
      busy_o    = (state_q != ST_IDLE);
      done_o    = (state_q == ST_FIN);
      err_tmo_o = err_q;
      stat_cnt_o = cnt_q;
   end

   // Datapath next values: config latch, counters, timeout flag, accumulator controls.
   always_comb begin
      len_d     = len_q;
      gap_d     = gap_q;
      cont_d    = cont_q;
      cnt_d     = cnt_q;
      gap_cnt_d = gap_cnt_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      clear_s   = 1'b0;
      capture_s = 1'b0;
      publish_s = 1'b0;
      if (!abort_i) begin
         case (state_q)
            ST_IDLE: begin
               if (start_ok_s) begin
                  len_d   = cfg_len_i;
                  gap_d   = cfg_gap_i;
                  cont_d  = cfg_cont_i;
                  err_d   = 1'b0;
                  cnt_d   = {LEN_W{1'b0}};
                  clear_s = 1'b1;
               end else begin
                  clear_s = 1'b0;
               end
            end
            ST_GO: tmo_d = {TW{1'b0}};
            ST_WAIT: begin
               if (edge_s) begin
                  capture_s = 1'b1;
                  publish_s = last_s;
                  cnt_d     = cnt_q + LEN_W'(1);
                  gap_cnt_d = {GAP_W{1'b0}};
               end else if (tmo_exp_s) begin
                  err_d = 1'b1;
               end else if (!adc_sample_i) begin
                  // Conversion in progress (SAMPLE high) holds the timeout.
                  tmo_d = tmo_q + TW'(1);
               end else begin
                  tmo_d = tmo_q;
               end
            end
            ST_GAP: gap_cnt_d = gap_cnt_q + GAP_W'(1);
            ST_FIN: begin
               if (rearm_s) begin
                  cnt_d   = {LEN_W{1'b0}};
                  clear_s = 1'b1;
               end else begin
                  clear_s = 1'b0;
               end
            end
            default: clear_s = 1'b0;
         endcase
      end else begin
         clear_s = 1'b0;
      end
   end

   // Datapath registers and VALID edge-detect history.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         len_q     <= {LEN_W{1'b0}};
         gap_q     <= {GAP_W{1'b0}};
         cont_q    <= 1'b0;
         cnt_q     <= {LEN_W{1'b0}};
         gap_cnt_q <= {GAP_W{1'b0}};
         tmo_q     <= {TW{1'b0}};
         err_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         len_q     <= len_d;
         gap_q     <= gap_d;
         cont_q    <= cont_d;
         cnt_q     <= cnt_d;
         gap_cnt_q <= gap_cnt_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         valid_q   <= adc_valid_i;
      end
   end

   adc_stat_accum #(
      .RES_W (RES_W),
      .LEN_W (LEN_W)
   ) u_accum (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (clear_s),
      .capture_i (capture_s),
      .publish_i (publish_s),
      .result_i  (adc_result_i),
      .sum_o     (stat_sum_o),
      .min_o     (stat_min_o),
      .max_o     (stat_max_o)
   );

endmodule

// File: tb/tb_adc_burst_sequencer.sv
// Directed bench for adc_burst_sequencer: table of bursts plus hand-written
// timeout, abort, continuous-mode and reset sequences.
module tb_adc_burst_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [7:0]  cfg_len = 8'd0;
   logic [7:0]  cfg_gap = 8'd0;
   logic        cfg_cont = 1'b0;
   logic        adc_valid = 1'b0;
   logic        adc_sample = 1'b0;
   logic [4:0]  adc_result = 5'd0;
   logic        adc_go, busy, done, err_tmo;
   logic [12:0] stat_sum;
   logic [4:0]  stat_min, stat_max;
   logic [7:0]  stat_cnt;

   int checks = 0;
   int errors = 0;
   int go_cnt = 0;
   int done_cnt = 0;

   typedef struct packed {
      logic [7:0]      len;
      logic [7:0]      gap;
      logic [3:0][4:0] res;
      logic [12:0]     sum;
      logic [4:0]      mn;
      logic [4:0]      mx;
   } vec_t;

   vec_t vecs [5];

   adc_burst_sequencer dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .abort_i      (abort),
      .cfg_len_i    (cfg_len),
      .cfg_gap_i    (cfg_gap),
      .cfg_cont_i   (cfg_cont),
      .adc_valid_i  (adc_valid),
      .adc_sample_i (adc_sample),
      .adc_result_i (adc_result),
      .adc_go_o     (adc_go),
      .busy_o       (busy),
      .done_o       (done),
      .err_tmo_o    (err_tmo),
      .stat_sum_o   (stat_sum),
      .stat_min_o   (stat_min),
      .stat_max_o   (stat_max),
      .stat_cnt_o   (stat_cnt)
   );

   always #5 clk = ~clk;

   // Pulse counters; sampled at posedge so they never race the negedge checks.
   always @(posedge clk) begin
      if (adc_go) go_cnt = go_cnt + 1;
      if (done)   done_cnt = done_cnt + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] len, input logic [7:0] gap,
                               input logic [4:0] r0, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] r3,
                               input logic [12:0] sum, input logic [4:0] mn,
                               input logic [4:0] mx);
      vec_t v;
      v.len = len; v.gap = gap;
      v.res[0] = r0; v.res[1] = r1; v.res[2] = r2; v.res[3] = r3;
      v.sum = sum; v.mn = mn; v.mx = mx;
      return v;
   endfunction

   // Request a burst; returns at the negedge where GO of conversion 1 shows.
   task automatic do_start(input logic [7:0] len, input logic [7:0] gap);
      cfg_len = len;
      cfg_gap = gap;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) until GO is visible at a negedge.
   task automatic wait_go(output int waited);
      waited = 0;
      while (!adc_go && waited < 300) begin
         @(negedge clk);
         waited = waited + 1;
      end
      if (!adc_go) check("go_wait_expired", 32'd0, 32'd1);
   endtask

   // ADC model: two WAIT cycles, then a one-cycle VALID with the result.
   // Returns at the negedge just after the edge was registered.
   task automatic respond(input logic [4:0] r);
      @(negedge clk);
      @(negedge clk);
      adc_valid = 1'b1;
      adc_result = r;
      @(negedge clk);
      adc_valid = 1'b0;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int k;
      int go0;
      int done0;
      go0 = go_cnt;
      done0 = done_cnt;
      do_start(v.len, v.gap);
      for (int i = 0; i < int'(v.len); i++) begin
         wait_go(k);
         if (i > 0) check($sformatf("v%0d_gap_spacing", idx), k, v.gap);
         respond(v.res[i]);
      end
      check($sformatf("v%0d_done", idx), done, 1);
      check($sformatf("v%0d_sum", idx), stat_sum, v.sum);
      check($sformatf("v%0d_min", idx), stat_min, v.mn);
      check($sformatf("v%0d_max", idx), stat_max, v.mx);
      check($sformatf("v%0d_cnt", idx), stat_cnt, v.len);
      @(negedge clk);
      check($sformatf("v%0d_idle", idx), busy, 0);
      check($sformatf("v%0d_done_pulses", idx), done_cnt - done0, 1);
      check($sformatf("v%0d_go_pulses", idx), go_cnt - go0, v.len);
   endtask

   initial begin
      int k;
      int d0;

      vecs[0] = mk(8'd4, 8'd0, 5'd3,  5'd17, 5'd9,  5'd31, 13'd60, 5'd3,  5'd31);
      vecs[1] = mk(8'd2, 8'd5, 5'd10, 5'd20, 5'd0,  5'd0,  13'd30, 5'd10, 5'd20);
      vecs[2] = mk(8'd1, 8'd0, 5'd0,  5'd0,  5'd0,  5'd0,  13'd0,  5'd0,  5'd0);
      vecs[3] = mk(8'd3, 8'd2, 5'd31, 5'd31, 5'd31, 5'd0,  13'd93, 5'd31, 5'd31);
      vecs[4] = mk(8'd4, 8'd1, 5'd16, 5'd1,  5'd30, 5'd2,  13'd49, 5'd1,  5'd30);

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_go", adc_go, 0);
      check("rst_done", done, 0);
      check("rst_err", err_tmo, 0);
      check("rst_sum", stat_sum, 0);
      check("rst_minmax", {stat_min, stat_max}, 0);
      check("rst_cnt", stat_cnt, 0);

      // Table-driven bursts
      for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

      // Timeout: 64 WAIT cycles after the GO cycle, flag visible on the next one
      d0 = done_cnt;
      do_start(8'd2, 8'd0);
      wait_go(k);
      k = 0;
      while (!err_tmo && k < 200) begin
         @(negedge clk);
         k = k + 1;
      end
      check("tmo_latency", k, 65);
      check("tmo_idle", busy, 0);
      check("tmo_sum_kept", stat_sum, 49);
      check("tmo_minmax_kept", {stat_min, stat_max}, {5'd1, 5'd30});
      @(negedge clk);
      check("tmo_no_done", done_cnt - d0, 0);

      // START with LEN=0 is ignored and leaves the flag set
      do_start(8'd0, 8'd0);
      @(negedge clk);
      check("len0_busy", busy, 0);
      check("len0_err_kept", err_tmo, 1);

      // Accepted START clears the flag; START while busy is ignored;
      // ABORT in WAIT of conversion 2 with a coincident VALID edge
      d0 = done_cnt;
      do_start(8'd4, 8'd0);
      check("restart_err_clr", err_tmo, 0);
      check("restart_go", adc_go, 1);
      respond(5'd5);
      check("abort_go2", adc_go, 1);
      check("abort_cnt1", stat_cnt, 1);
      do_start(8'd2, 8'd3);
      check("busy_start_cnt", stat_cnt, 1);
      check("busy_start_busy", busy, 1);
      abort = 1'b1;
      adc_valid = 1'b1;
      adc_result = 5'd0;
      @(negedge clk);
      abort = 1'b0;
      adc_valid = 1'b0;
      check("abort_idle", busy, 0);
      check("abort_go", adc_go, 0);
      check("abort_edge_dropped", stat_cnt, 1);
      @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      check("abort_sum_kept", stat_sum, 49);
      check("abort_minmax_kept", {stat_min, stat_max}, {5'd1, 5'd30});

      // Continuous mode: back-to-back bursts, then one more after CONT clears
      d0 = done_cnt;
      cfg_cont = 1'b1;
      do_start(8'd3, 8'd0);
      for (int i = 1; i <= 3; i++) begin
         wait_go(k);
         respond(5'(i));
      end
      check("cont_done1", done, 1);
      check("cont_sum1", stat_sum, 6);
      check("cont_minmax1", {stat_min, stat_max}, {5'd1, 5'd3});
      @(negedge clk);
      check("cont_rearm_go", adc_go, 1);
      check("cont_rearm_cnt", stat_cnt, 0);
      cfg_cont = 1'b0;
      for (int i = 4; i <= 6; i++) begin
         wait_go(k);
         respond(5'(i));
      end
      check("cont_done2", done, 1);
      check("cont_sum2", stat_sum, 15);
      check("cont_minmax2", {stat_min, stat_max}, {5'd4, 5'd6});
      @(negedge clk);
      check("cont_end_idle", busy, 0);
      check("cont_end_go", adc_go, 0);
      check("cont_done_pulses", done_cnt - d0, 2);

      // Asynchronous reset mid-WAIT, away from any clock edge
      do_start(8'd4, 8'd0);
      @(negedge clk);
      check("rst2_in_wait", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("rst2_busy", busy, 0);
      check("rst2_sum", stat_sum, 0);
      check("rst2_minmax", {stat_min, stat_max}, 0);
      check("rst2_cnt_go", {stat_cnt, adc_go, done, err_tmo}, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst2_after", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_time_limit actual=expired required=finished");
      $fatal(1);
   end

endmodule
